aes_key_expansion: RTL

Iterative AES-128 round-key generator that sits directly upstream of the key-addition stage and supplies its `subkey` operand. It loads a 128-bit cipher key, then produces round keys 0..10 one per advance request, one clock per step. The round counter and key register are held internally, so the round datapath only needs to pulse `next` once per round and consume `subkey`.

---
 rtl/aes_key_expansion.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expansion.sv
// -----------------------------------------------------------------------------
// aes_key_expansion
//
// Iterative AES-128 round-key generator. A cipher key is captured with `load`
// and becomes round key 0; each accepted `next` then steps one round, one
// clock per step, so the round datapath only pulses `next` and consumes
// `subkey`.
//
// Optional feature macro: AES_KEYEXP_INV_EN
//   When defined, `dir`=1 turns a `next` into a backward step (round-1) so the
//   decryption path can walk from round 10 down to round 0. When undefined,
//   `dir` is ignored and every accepted `next` steps forward.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst        in   1    synchronous active-high reset
//   key_in     in   128  cipher key, sampled only while load=1
//   load       in   1    capture key_in as round key 0 (priority over next)
//   next       in   1    step one round
//   dir        in   1    0 = forward, 1 = backward (macro builds only)
//   subkey     out  128  current round key; [127:96] = w0, [31:0] = w3
//   round_idx  out  4    index of the key on subkey, 0..10
//   valid      out  1    subkey derives from a loaded key
//   done       out  1    round_idx == 10 and valid
//
// All outputs are taken straight from flops.
// -----------------------------------------------------------------------------
module aes_key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         load,
    input  logic         next,
    input  logic         dir,
    output logic [127:0] subkey,
    output logic [3:0]   round_idx,
    output logic         valid,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [10:0] bit_ofs;
        bit_ofs   = {a, 3'b000};
        sbox_byte = SBOX_TABLE[(11'd2047 - bit_ofs) -: 8];
    endfunction

    // SubWord(RotWord(w)): rotate bytes left by one, then substitute each.
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        sub_rot_word = {sbox_byte(r[31:24]), sbox_byte(r[23:16]),
                        sbox_byte(r[15:8]),  sbox_byte(r[7:0])};
    endfunction

    // Round constant for the key of round r (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [127:0] key_q,   key_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         done_q,  done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in;     // word fed to the shared S-box row
    logic [7:0]  rcon_sel;
    logic [31:0] t_word;     // SubWord(RotWord(sub_in)) ^ rcon
    logic [127:0] fwd_key;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

`ifdef AES_KEYEXP_INV_EN
    logic [127:0] bwd_key;
    logic [31:0]  bw1, bw2, bw3;

    // Backward step recovers w3..w1 of the previous round by XOR-ing
    // neighbours, then rebuilds w0 from the recovered w3. One S-box row is
    // shared between directions by muxing its input word and rcon.
    assign bw3      = w3 ^ w2;
    assign bw2      = w2 ^ w1;
    assign bw1      = w1 ^ w0;
    assign sub_in   = dir ? bw3 : w3;
    assign rcon_sel = dir ? rcon(round_q) : rcon(round_q + 4'd1);
    assign bwd_key  = {w0 ^ t_word, bw1, bw2, bw3};
`else
    logic dir_unused;
    assign dir_unused = dir;
    assign sub_in     = w3;
    assign rcon_sel   = rcon(round_q + 4'd1);
`endif

    assign t_word = sub_rot_word(sub_in) ^ {rcon_sel, 24'h000000};

    // Forward XOR chain: each new word folds in the previous new word.
    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        n0 = w0 ^ t_word;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        fwd_key = {n0, n1, n2, n3};
    end

    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        if (load) begin
            key_d   = key_in;
            round_d = 4'd0;
            valid_d = 1'b1;
        end else if (next && valid_q) begin
`ifdef AES_KEYEXP_INV_EN
            if (dir) begin
                if (round_q != 4'd0) begin
                    key_d   = bwd_key;
                    round_d = round_q - 4'd1;
                end
            end else if (round_q < LAST_ROUND) begin
                key_d   = fwd_key;
                round_d = round_q + 4'd1;
            end
`else
            if (round_q < LAST_ROUND) begin
                key_d   = fwd_key;
                round_d = round_q + 4'd1;
            end
`endif
        end
        // Registered so done has no path from the inputs.
        done_d = valid_d && (round_d == LAST_ROUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign subkey    = key_q;
    assign round_idx = round_q;
    assign valid     = valid_q;
    assign done      = done_q;

endmodule
